// File: rtl/ata_pio_tctrl_if.sv
// Host-side request/response bundle between the WISHBONE decode stage and the PIO timing engine.
`timescale 1ns/1ps
interface ata_pio_tctrl_if #(
    parameter int unsigned TWIDTH = 8
) ();
    logic              go;
    logic              we;
    logic [3:0]        a;
    logic [15:0]       d;
    logic [TWIDTH-1:0] T1;
    logic [TWIDTH-1:0] T2;
    logic [TWIDTH-1:0] T4;
    logic [TWIDTH-1:0] Teoc;
    logic              IORDYen;
    logic              busy;
    logic              done;
    logic [15:0]       q;

    modport master (
        output go, we, a, d, T1, T2, T4, Teoc, IORDYen,
        input  busy, done, q
    );

    modport slave (
        input  go, we, a, d, T1, T2, T4, Teoc, IORDYen,
        output busy, done, q
    );
endinterface

// File: rtl/ata_pio_tctrl.sv
// PIO timing engine: turns one host request into a full ATA PIO bus cycle (setup, strobe with
// optional IORDY stretch, hold/end-of-cycle recovery). All outputs are registered.
`timescale 1ns/1ps
module ata_pio_tctrl #(
    parameter int unsigned TWIDTH = 8
) (
    input  logic              CLK_I,
    input  logic              nReset,
    input  logic              RST_I,
    ata_pio_tctrl_if.slave    host,
    input  logic              IORDY,
    input  logic [15:0]       DDi,
    output logic [15:0]       DDo,
    output logic              DDoe,
    output logic [2:0]        DA,
    output logic              CS0n,
    output logic              CS1n,
    output logic              DIORn,
    output logic              DIOWn
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state;
    logic [TWIDTH-1:0] cnt;
    logic [TWIDTH-1:0] holdcnt;
    logic [TWIDTH-1:0] eoccnt;
    logic [TWIDTH-1:0] t2_r;
    logic [TWIDTH-1:0] t4_r;
    logic [TWIDTH-1:0] teoc_r;
    logic              we_r;
    logic              iordyen_r;
    logic              iordy_s1;
    logic              iordy_s2;

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            state     <= StIdle;
            cnt       <= '0;
            holdcnt   <= '0;
            eoccnt    <= '0;
            t2_r      <= '0;
            t4_r      <= '0;
            teoc_r    <= '0;
            we_r      <= 1'b0;
            iordyen_r <= 1'b0;
            iordy_s1  <= 1'b0;
            iordy_s2  <= 1'b0;
            DDo       <= '0;
            DDoe      <= 1'b0;
            DA        <= '0;
            CS0n      <= 1'b1;
            CS1n      <= 1'b1;
            DIORn     <= 1'b1;
            DIOWn     <= 1'b1;
            host.busy <= 1'b0;
            host.done <= 1'b0;
            host.q    <= '0;
        end else if (RST_I) begin
            state     <= StIdle;
            cnt       <= '0;
            holdcnt   <= '0;
            eoccnt    <= '0;
            t2_r      <= '0;
            t4_r      <= '0;
            teoc_r    <= '0;
            we_r      <= 1'b0;
            iordyen_r <= 1'b0;
            iordy_s1  <= 1'b0;
            iordy_s2  <= 1'b0;
            DDo       <= '0;
            DDoe      <= 1'b0;
            DA        <= '0;
            CS0n      <= 1'b1;
            CS1n      <= 1'b1;
            DIORn     <= 1'b1;
            DIOWn     <= 1'b1;
            host.busy <= 1'b0;
            host.done <= 1'b0;
            host.q    <= '0;
        end else begin
            iordy_s1  <= IORDY;
            iordy_s2  <= iordy_s1;
            host.done <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (host.go) begin
                        we_r      <= host.we;
                        iordyen_r <= host.IORDYen;
                        t2_r      <= host.T2;
                        t4_r      <= host.T4;
                        teoc_r    <= host.Teoc;
                        cnt       <= host.T1;
                        DA        <= host.a[2:0];
                        CS0n      <= host.a[3];
                        CS1n      <= ~host.a[3];
                        if (host.we) begin
                            DDo  <= host.d;
                            DDoe <= 1'b1;
                        end
                        host.busy <= 1'b1;
                        state     <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt == '0) begin
                        DIORn <= we_r;
                        DIOWn <= ~we_r;
                        cnt   <= t2_r;
                        state <= StStrobe;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                StStrobe: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!(iordyen_r && !iordy_s2)) begin
                        // Strobe only ends once the device has released IORDY (or IORDY is ignored).
                        DIORn     <= 1'b1;
                        DIOWn     <= 1'b1;
                        host.done <= 1'b1;
                        if (!we_r) begin
                            host.q <= DDi;
                        end
                        holdcnt <= t4_r;
                        eoccnt  <= teoc_r;
                        state   <= StHold;
                    end
                end

                StHold: begin
                    if (holdcnt == '0) begin
                        CS0n <= 1'b1;
                        CS1n <= 1'b1;
                        DDoe <= 1'b0;
                    end else begin
                        holdcnt <= holdcnt - 1'b1;
                    end
                    if (eoccnt != '0) begin
                        eoccnt <= eoccnt - 1'b1;
                    end
                    if (holdcnt == '0 && eoccnt == '0) begin
                        host.busy <= 1'b0;
                        state     <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ata_pio_tctrl.sv
// Directed bench for ata_pio_tctrl: outputs sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_ata_pio_tctrl;

    logic        CLK_I = 1'b0;
    logic        nReset;
    logic        RST_I;
    logic        IORDY;
    logic [15:0] DDi;
    logic [15:0] DDo;
    logic        DDoe;
    logic [2:0]  DA;
    logic        CS0n, CS1n, DIORn, DIOWn;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    ata_pio_tctrl_if #(.TWIDTH(8)) bus ();

    ata_pio_tctrl #(.TWIDTH(8)) dut (
        .CLK_I  (CLK_I),
        .nReset (nReset),
        .RST_I  (RST_I),
        .host   (bus.slave),
        .IORDY  (IORDY),
        .DDi    (DDi),
        .DDo    (DDo),
        .DDoe   (DDoe),
        .DA     (DA),
        .CS0n   (CS0n),
        .CS1n   (CS1n),
        .DIORn  (DIORn),
        .DIOWn  (DIOWn)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic [3:0] aa, input logic [15:0] dd,
                         input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t4,
                         input logic [7:0] teoc, input logic ien);
        bus.we      = w;
        bus.a       = aa;
        bus.d       = dd;
        bus.T1      = t1;
        bus.T2      = t2;
        bus.T4      = t4;
        bus.Teoc    = teoc;
        bus.IORDYen = ien;
        bus.go      = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int nb;
        int ns;
        logic pb;
        logic pw;

        nReset = 1'b0; RST_I = 1'b0; IORDY = 1'b1; DDi = '0;
        bus.go = 1'b0; bus.we = 1'b0; bus.a = '0; bus.d = '0;
        bus.T1 = '0; bus.T2 = '0; bus.T4 = '0; bus.Teoc = '0; bus.IORDYen = 1'b0;
        tick(); tick();

        chk("rst_diorn", 32'(DIORn), 32'd1);
        chk("rst_diown", 32'(DIOWn), 32'd1);
        chk("rst_cs0n",  32'(CS0n),  32'd1);
        chk("rst_cs1n",  32'(CS1n),  32'd1);
        chk("rst_da",    32'(DA),    32'd0);
        chk("rst_ddo",   32'(DDo),   32'd0);
        chk("rst_q",     32'(bus.q), 32'd0);
        chk("rst_ddoe",  32'(DDoe),  32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        nReset = 1'b1;
        tick();

        // Write with default timings
        start(1'b1, 4'b0111, 16'hA55A, 8'd6, 8'd28, 8'd2, 8'd23, 1'b0);
        d0 = done_cnt;
        tick();
        bus.go = 1'b0;
        chk("wr_cs0n", 32'(CS0n), 32'd0);
        chk("wr_cs1n", 32'(CS1n), 32'd1);
        chk("wr_da",   32'(DA),   32'd7);
        chk("wr_ddoe", 32'(DDoe), 32'd1);
        chk("wr_ddo",  32'(DDo),  32'hA55A);
        chk("wr_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (DIOWn === 1'b1 && n < 100) begin tick(); n++; end
        chk("wr_setup_len", 32'(n), 32'd7);
        n = 0;
        while (DIOWn === 1'b0 && n < 100) begin tick(); n++; end
        chk("wr_strobe_len", 32'(n), 32'd29);
        chk("wr_done", 32'(bus.done), 32'd1);
        chk("wr_diorn", 32'(DIORn), 32'd1);
        n = 0;
        while (DDoe === 1'b1 && n < 100) begin tick(); n++; end
        chk("wr_ddoe_hold", 32'(n), 32'd3);
        chk("wr_cs0n_end", 32'(CS0n), 32'd1);
        while (bus.busy === 1'b1 && n < 100) begin tick(); n++; end
        chk("wr_busy_end", 32'(n), 32'd24);
        chk("wr_done_once", 32'(done_cnt - d0), 32'd1);
        chk("wr_q_kept", 32'(bus.q), 32'd0);

        // Read, all timings zero
        DDi = 16'h1234;
        start(1'b0, 4'b1110, 16'h0000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        d0 = done_cnt;
        tick();
        bus.go = 1'b0;
        chk("rd_cs1n", 32'(CS1n), 32'd0);
        chk("rd_cs0n", 32'(CS0n), 32'd1);
        chk("rd_da",   32'(DA),   32'd6);
        chk("rd_ddoe0", 32'(DDoe), 32'd0);
        tick();
        chk("rd_diorn_low", 32'(DIORn), 32'd0);
        chk("rd_ddoe1", 32'(DDoe), 32'd0);
        chk("rd_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("rd_diorn_high", 32'(DIORn), 32'd1);
        chk("rd_done", 32'(bus.done), 32'd1);
        chk("rd_q", 32'(bus.q), 32'h1234);
        tick();
        chk("rd_busy_end", 32'(bus.busy), 32'd0);
        chk("rd_cs1n_end", 32'(CS1n), 32'd1);
        chk("rd_done_once", 32'(done_cnt - d0), 32'd1);

        // IORDY stretch
        IORDY = 1'b0;
        tick(); tick(); tick();
        DDi = 16'hBEEF;
        start(1'b0, 4'b0000, 16'h0000, 8'd0, 8'd2, 8'd0, 8'd0, 1'b1);
        d0 = done_cnt;
        tick();
        bus.go = 1'b0;
        tick();
        chk("io_strobe", 32'(DIORn), 32'd0);
        repeat (12) tick();
        chk("io_stretch", 32'(DIORn), 32'd0);
        chk("io_no_done", 32'(done_cnt - d0), 32'd0);
        IORDY = 1'b1;
        n = 0;
        while (DIORn === 1'b0 && n < 20) begin tick(); n++; end
        chk("io_release_2to3", 32'(n >= 2 && n <= 3), 32'd1);
        chk("io_q", 32'(bus.q), 32'hBEEF);
        wait_idle();
        tick();
        chk("io_done_once", 32'(done_cnt - d0), 32'd1);

        // IORDY ignored
        IORDY = 1'b0;
        tick(); tick(); tick();
        start(1'b1, 4'b0001, 16'h0F0F, 8'd1, 8'd5, 8'd0, 8'd0, 1'b0);
        tick();
        bus.go = 1'b0;
        n = 0;
        while (DIOWn === 1'b1 && n < 100) begin tick(); n++; end
        chk("noio_setup", 32'(n), 32'd2);
        n = 0;
        while (DIOWn === 1'b0 && n < 100) begin tick(); n++; end
        chk("noio_width", 32'(n), 32'd6);
        wait_idle();
        IORDY = 1'b1;

        // go held for 100 cycles: one 10-cycle bus cycle per busy window
        start(1'b1, 4'b0010, 16'h1111, 8'd1, 8'd2, 8'd1, 8'd3, 1'b0);
        d0 = done_cnt;
        pb = 1'b0; pw = 1'b1; nb = 0; ns = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.busy === 1'b1 && !pb) nb++;
            if (DIOWn === 1'b0 && pw) ns++;
            pb = bus.busy;
            pw = DIOWn;
        end
        bus.go = 1'b0;
        chk("held_busy_windows", 32'(nb), 32'd10);
        chk("held_strobes", 32'(ns), 32'd10);
        chk("held_done", 32'(done_cnt - d0), 32'd10);
        chk("held_idle", 32'(bus.busy), 32'd0);
        chk("q_after_writes", 32'(bus.q), 32'hBEEF);

        // Async reset in the middle of the strobe
        start(1'b1, 4'b0011, 16'hCAFE, 8'd0, 8'd20, 8'd0, 8'd0, 1'b0);
        d0 = done_cnt;
        tick();
        bus.go = 1'b0;
        tick();
        chk("arst_pre_strobe", 32'(DIOWn), 32'd0);
        #2 nReset = 1'b0;
        #1;
        chk("arst_diown", 32'(DIOWn), 32'd1);
        chk("arst_cs0n",  32'(CS0n),  32'd1);
        chk("arst_busy",  32'(bus.busy), 32'd0);
        chk("arst_q",     32'(bus.q), 32'd0);
        chk("arst_ddoe",  32'(DDoe),  32'd0);
        tick();
        nReset = 1'b1;
        repeat (5) tick();
        chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

        // Sync reset mid-strobe acts only at the edge
        start(1'b0, 4'b1000, 16'h0000, 8'd0, 8'd10, 8'd0, 8'd0, 1'b0);
        tick();
        bus.go = 1'b0;
        tick();
        chk("srst_pre", 32'(DIORn), 32'd0);
        RST_I = 1'b1;
        #1;
        chk("srst_not_async", 32'(DIORn), 32'd0);
        tick();
        RST_I = 1'b0;
        chk("srst_diorn", 32'(DIORn), 32'd1);
        chk("srst_cs1n",  32'(CS1n),  32'd1);
        chk("srst_busy",  32'(bus.busy), 32'd0);

        // Normal read after reset
        DDi = 16'h5A5A;
        start(1'b0, 4'b0100, 16'h0000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        bus.go = 1'b0;
        chk("post_cs0n", 32'(CS0n), 32'd0);
        tick();
        tick();
        chk("post_done", 32'(bus.done), 32'd1);
        chk("post_q", 32'(bus.q), 32'h5A5A);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
